// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the 8-bit combinational ALU. It reads operands from a
// small register file, drives the ALU, writes the result back and returns it on a response channel.
module alu_cmd_sequencer #(
   parameter int NREGS = 8,
   parameter int W = 8,
   localparam int RW = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [3:0]    cmd_op,
   input  logic [RW-1:0] cmd_src_a,
   input  logic [RW-1:0] cmd_src_b,
   input  logic [RW-1:0] cmd_dst,
   input  logic          wr_en,
   input  logic [RW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   output logic [W-1:0]  alu_a,
   output logic [W-1:0]  alu_b,
   output logic [3:0]    alu_sel,
   input  logic [W-1:0]  alu_out,
   input  logic [3:0]    alu_flag,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [W-1:0]  rsp_data,
   output logic [3:0]    rsp_flag,
   output logic          rsp_err,
   output logic          busy
);

   // state | meaning
   // IDLE  | waiting for a command, cmd_ready high
   // EXEC  | ALU inputs settled, capture result and write back on next edge
   // RESP  | response held until rsp_ready
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t        state;
   logic [W-1:0]  rf [NREGS];
   logic [RW-1:0] dst;
   logic          reject;

   // Divide by zero is refused here so the ALU never sees it.
   assign reject = (cmd_op >= 4'hC) || ((cmd_op == 4'd3) && (rf[cmd_src_b] == '0));

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
         dst       <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_flag  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (wr_en) rf[wr_addr] <= wr_data;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  dst <= cmd_dst;
                  if (reject) begin
                     rsp_err   <= 1'b1;
                     rsp_data  <= '0;
                     rsp_flag  <= '0;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     alu_a   <= rf[cmd_src_a];
                     alu_b   <= rf[cmd_src_b];
                     alu_sel <= cmd_op;
                     state   <= EXEC;
                  end
               end
            end
            EXEC: begin
               rsp_data  <= alu_out;
               rsp_flag  <= alu_flag;
               rsp_err   <= 1'b0;
               rsp_valid <= 1'b1;
               // Placed after the direct load so the ALU result wins a same-index collision.
               rf[dst]   <= alu_out;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU plus a register-file reference model,
// directed scenarios followed by randomized commands.
module tb_alu_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [2:0] cmd_src_a, cmd_src_b, cmd_dst;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] alu_a, alu_b;
   logic [3:0] alu_sel;
   logic [7:0] alu_out;
   logic [3:0] alu_flag;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic [3:0] rsp_flag;
   logic       rsp_err;
   logic       busy;

   int errors = 0;
   int checks = 0;

   logic [7:0] mrf [8];
   logic [7:0] exp_a, exp_b;
   logic [3:0] exp_sel;

   always #5 clk = ~clk;

   alu_cmd_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_flag(alu_flag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_flag(rsp_flag), .rsp_err(rsp_err),
      .busy(busy)
   );

   // ALU stand-in; returns {flag, out}. Zero suppresses the other flags.
   function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] s);
      logic [8:0]  t;
      logic [15:0] p;
      logic [7:0]  o;
      logic        c, v, u;
      t = '0; p = '0; o = '0; c = 1'b0; v = 1'b0; u = 1'b0;
      case (s)
         4'd0: begin t = {1'b0, a} + {1'b0, b}; o = t[7:0]; c = t[8]; end
         4'd1: begin o = a - b; u = (a < b); end
         4'd2: begin p = {8'h00, a} * {8'h00, b}; o = p[7:0]; v = (p[15:8] != 8'h00); end
         4'd3: o = (b == 8'h00) ? 8'h00 : a / b;
         4'd4: begin o = {a[6:0], 1'b0}; c = a[7]; end
         4'd5: begin o = {1'b0, a[7:1]}; c = a[0]; end
         4'd6: o = a & b;
         4'd7: o = a | b;
         4'd8: o = a ^ b;
         4'd9: o = ~(a ^ b);
         4'd10: o = ~(a & b);
         4'd11: o = ~(a | b);
         default: o = 8'h00;
      endcase
      if (o == 8'h00) return {4'h8, o};
      return {1'b0, c, v, u, o};
   endfunction

   assign {alu_flag, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
      mrf[a] = d;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mrf[i] = 8'h00;
      exp_a = 8'h00; exp_b = 8'h00; exp_sel = 4'h0;
   endtask

   task automatic do_cmd(input logic [3:0] op, input logic [2:0] sa, input logic [2:0] sb,
                         input logic [2:0] d,
                         input bit aw, input logic [2:0] awa, input logic [7:0] awd,
                         input bit ew, input logic [2:0] ewa, input logic [7:0] ewd,
                         input int hold, input bit early);
      logic [11:0] r;
      logic [7:0]  va, vb;
      bit          rej;
      chk("cmd_ready_idle", cmd_ready, 1);
      va  = mrf[sa];
      vb  = mrf[sb];
      rej = (op >= 4'hC) || (op == 4'd3 && vb == 8'h00);
      r   = rej ? 12'h000 : alu_fn(va, vb, op);
      cmd_valid = 1'b1; cmd_op = op; cmd_src_a = sa; cmd_src_b = sb; cmd_dst = d;
      wr_en = aw; wr_addr = awa; wr_data = awd;
      rsp_ready = early;
      tick();
      cmd_valid = 1'b0; wr_en = 1'b0;
      if (aw) mrf[awa] = awd;
      if (!rej) begin exp_a = va; exp_b = vb; exp_sel = op; end
      chk("alu_a", alu_a, exp_a);
      chk("alu_b", alu_b, exp_b);
      chk("alu_sel", alu_sel, exp_sel);
      chk("busy_after_accept", busy, 1);
      chk("cmd_ready_after_accept", cmd_ready, 0);
      if (!rej) begin
         chk("rsp_valid_exec", rsp_valid, 0);
         wr_en = ew; wr_addr = ewa; wr_data = ewd;
         tick();
         wr_en = 1'b0;
         if (ew) mrf[ewa] = ewd;
         mrf[d] = r[7:0];
      end
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, r[7:0]);
      chk("rsp_flag", rsp_flag, r[11:8]);
      chk("rsp_err", rsp_err, rej);
      if (hold > 0) begin
         rsp_ready = 1'b0;
         cmd_valid = 1'b1; cmd_op = 4'd0; cmd_src_a = 3'd0; cmd_src_b = 3'd0; cmd_dst = 3'd0;
         for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_data", rsp_data, r[7:0]);
            chk("hold_rsp_flag", rsp_flag, r[11:8]);
            chk("hold_cmd_ready", cmd_ready, 0);
         end
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      chk("rsp_valid_after_hs", rsp_valid, 0);
      chk("cmd_ready_after_hs", cmd_ready, 1);
   endtask

   // src_a == src_b == dst with And rewrites the register with itself and returns it.
   task automatic peek(input logic [2:0] i, input logic [7:0] exp);
      do_cmd(4'd6, i, i, i, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0);
      chk("peek", rsp_data, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; rsp_ready = 1'b0;
      model_reset();
      tick();
      // traffic during reset must be dropped
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'hAA;
      cmd_valid = 1'b1; cmd_op = 4'd0;
      tick(); tick();
      wr_en = 1'b0; cmd_valid = 1'b0;
      rst_n = 1'b1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_flag", rsp_flag, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_sel", alu_sel, 0);
      peek(3'd1, 8'h00);

      wr(3'd1, 8'hF0); wr(3'd2, 8'h20);
      do_cmd(4'd0, 3'd1, 3'd2, 3'd3, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0);
      chk("add_data", rsp_data, 8'h10);
      chk("add_flag", rsp_flag, 4'h4);
      peek(3'd3, 8'h10);

      wr(3'd1, 8'h10);
      do_cmd(4'd1, 3'd1, 3'd2, 3'd4, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0);
      chk("sub_data", rsp_data, 8'hF0);
      chk("sub_flag", rsp_flag, 4'h1);
      wr(3'd0, 8'h10);
      do_cmd(4'd0, 3'd4, 3'd0, 3'd5, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0);
      chk("zero_data", rsp_data, 8'h00);
      chk("zero_flag", rsp_flag, 4'h8);

      // rejected commands
      wr(3'd6, 8'h5A);
      do_cmd(4'hC, 3'd1, 3'd2, 3'd6, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0);
      chk("illegal_err", rsp_err, 1);
      wr(3'd2, 8'h00);
      do_cmd(4'd3, 3'd1, 3'd2, 3'd6, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0);
      chk("div0_err", rsp_err, 1);
      peek(3'd6, 8'h5A);

      // stalled response, then write collisions
      do_cmd(4'd7, 3'd1, 3'd4, 3'd6, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 5, 0);
      wr(3'd2, 8'h20);
      do_cmd(4'd0, 3'd1, 3'd2, 3'd7, 0, 3'd0, 8'h00, 1, 3'd7, 8'h55, 0, 0);
      peek(3'd7, 8'h30);
      do_cmd(4'd0, 3'd1, 3'd2, 3'd7, 0, 3'd0, 8'h00, 1, 3'd5, 8'h77, 0, 0);
      peek(3'd5, 8'h77);
      peek(3'd7, 8'h30);
      do_cmd(4'd0, 3'd1, 3'd2, 3'd3, 1, 3'd1, 8'h99, 0, 3'd0, 8'h00, 0, 0);
      chk("acc_edge_old_operand", rsp_data, 8'h30);
      peek(3'd1, 8'h99);

      // reset while in EXEC
      cmd_valid = 1'b1; cmd_op = 4'd0; cmd_src_a = 3'd1; cmd_src_b = 3'd2; cmd_dst = 3'd4;
      tick();
      cmd_valid = 1'b0;
      chk("exec_busy", busy, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      model_reset();
      chk("abort_rsp_valid", rsp_valid, 0);
      chk("abort_cmd_ready", cmd_ready, 1);
      chk("abort_alu_a", alu_a, 0);
      chk("abort_alu_sel", alu_sel, 0);
      chk("abort_rsp_data", rsp_data, 0);
      tick();
      chk("abort_rsp_valid_later", rsp_valid, 0);
      peek(3'd4, 8'h00);
      peek(3'd1, 8'h00);

      // randomized commands against the model
      for (int n = 0; n < 60; n++) begin
         logic [2:0] wa1, wa2;
         wa1 = 3'($urandom_range(0, 7));
         wa2 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) wr(3'($urandom_range(0, 7)), 8'($urandom));
         do_cmd(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)),
                ($urandom_range(0, 2) == 0), wa1, 8'($urandom),
                ($urandom_range(0, 2) == 0), wa2, 8'($urandom),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0,
                ($urandom_range(0, 1) == 1));
      end
      for (int i = 0; i < 8; i++) peek(3'(i), mrf[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-driven front end for the 8-bit combinational ALU: accepts operation commands over a valid/ready channel, reads operands from an internal register file, drives the ALU's A/B/Sel inputs, captures Out/Flag, writes the result back and returns it over a valid/ready response channel. It sits between the instruction/control logic and the ALU and owns all sequencing the ALU lacks.

## Interface
- NREGS, 8, register-file depth; power of two; index width RW = log2(NREGS)
- W, 8, data width; fixed to the ALU width, not to be overridden
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  4  ALU opcode: 0 Add, 1 Sub, 2 Mul, 3 Div, 4 Shl, 5 Shr, 6 And, 7 Or, 8 Xor, 9 Nxor, A Nand, B Nor; C-F illegal
- cmd_src_a / cmd_src_b  in  RW  operand register indices
- cmd_dst  in  RW  destination register index
- wr_en  in  1  direct register load strobe
- wr_addr  in  RW  direct load index
- wr_data  in  W  direct load data
- alu_a / alu_b  out  W  registered operands to ALU
- alu_sel  out  4  registered opcode to ALU
- alu_out  in  W  ALU result (combinational from alu_a/alu_b/alu_sel)
- alu_flag  in  4  ALU flags: bit3 Zero, bit2 Carry, bit1 Overflow, bit0 Underflow
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  W  result
- rsp_flag  out  4  captured flags
- rsp_err  out  1  command rejected
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, RESP.
- cmd_ready = (state == IDLE); busy = !cmd_ready.
- IDLE, cmd_valid & cmd_ready: latch cmd_dst; then
  - illegal op (C-F), or op 3 with rf[cmd_src_b] == 0: rsp_err<=1, rsp_data<=0, rsp_flag<=0 -> RESP; ALU ports unchanged; no writeback.
  - otherwise: alu_a<=rf[cmd_src_a], alu_b<=rf[cmd_src_b], alu_sel<=cmd_op -> EXEC.
- EXEC (exactly one cycle): rsp_data<=alu_out, rsp_flag<=alu_flag, rsp_err<=0, rf[dst]<=alu_out -> RESP.
- RESP: rsp_valid=1; rsp_data/flag/err stable; on rsp_ready -> IDLE. rsp_ready outside RESP ignored.
- alu_a/alu_b/alu_sel hold last issued values in IDLE and RESP.
- Direct load: wr_en writes rf[wr_addr]<=wr_data in any state.
- Same-edge conflicts: EXEC writeback to the same index as wr_en wins; different indices both write. Operand read at accept edge sees pre-edge register values (no bypass of a same-edge wr_en).
- src_a == src_b == dst allowed; result overwrites operand after read.
- Arithmetic and flags are entirely the ALU's; the sequencer does not modify them.

## Timing
- Reset (rst_n low at edge): state IDLE; all rf entries 0; alu_a, alu_b 0; alu_sel 0; rsp_data 0; rsp_flag 0; rsp_err 0; rsp_valid 0. cmd_ready reads 1 after the reset edge; commands and wr_en sampled while rst_n is low are dropped. Reset during EXEC or RESP aborts the op with no writeback and no response.
- Legal op: accept edge E0; ALU inputs valid after E0; capture/writeback at E1; rsp_valid high from E1 until the handshake edge.
- Rejected op: rsp_valid high from E0.
- Minimum accept-to-accept period: 3 cycles legal (rsp_ready held high), 2 cycles rejected.
- No command accepted in the cycle a response handshakes (cmd_ready low in RESP).

## Test plan
- Reset, then load r1=0xF0, r2=0x20; Add dst r3 -> rsp_valid 2 cycles after accept, rsp_data 0x10, rsp_flag 0x4, rsp_err 0; r3 == 0x10.
- r1=0x10, r2=0x20; Sub dst r4 -> rsp_data 0xF0, rsp_flag 0x1; then Add r4+r0 dst r5 with r0=0x10 -> 0x00, flag 0x8.
- cmd_op 0xC, and Div with r2=0 -> rsp_err 1 in next cycle, rsp_data 0, rsp_flag 0, destination unchanged, ALU ports unchanged.
- rsp_ready held low 5 cycles in RESP -> rsp_* stable, cmd_ready 0, new cmd_valid not accepted; accepted in cycle after handshake.
- wr_en to dst on EXEC writeback edge -> ALU result kept; wr_en to other index same edge -> both written; wr_en to src on accept edge -> old operand used.
- rst_n low during EXEC -> no writeback, rsp_valid 0, all outputs/registers 0, cmd_ready 1 after release.
